// File: rtl/fft_pkg.sv
// Shared constants, types and index helpers for the 32-point SDF FFT datapath.
package fft_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int DW    = 19;

    // Widest index the generic bit reversal helper handles.
    localparam int REV_W = 16;

    // Signed sample type shared with the butterfly stages.
    typedef logic signed [DW-1:0] sample_t;

    // Read-side FSM states of the reorder buffer.
    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_e;

    // Reverse the low w bits of a; bits above w come back as zero.
    function automatic logic [REV_W-1:0] bitrev_w(input logic [REV_W-1:0] a, input int w);
        logic [REV_W-1:0] r;
        for (int b = 0; b < REV_W; b++) begin
            r[b] = a[REV_W-1-b];
        end
        return r >> (REV_W - w);
    endfunction

    // Reverse a LOG2N-bit frame index, e.g. 5'b00001 -> 5'b10000.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        return LOG2N'(bitrev_w(REV_W'(a), LOG2N));
    endfunction

endpackage

// File: rtl/fft_reorder_buf_if.sv
// Sample stream bundle around the reorder buffer: bit-reversed samples in,
// natural-order samples with index and frame markers out.
interface fft_reorder_buf_if #(
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int DW    = fft_pkg::DW
);
    logic                    valid_i;
    logic signed [DW-1:0]    in_r;
    logic signed [DW-1:0]    in_i;
    logic                    valid_o;
    logic signed [DW-1:0]    out_r;
    logic signed [DW-1:0]    out_i;
    logic [LOG2N-1:0]        idx_o;
    logic                    sop_o;
    logic                    eop_o;

    // Producer / consumer side: drives the input stream, observes the output stream.
    modport master (
        output valid_i, in_r, in_i,
        input  valid_o, out_r, out_i, idx_o, sop_o, eop_o
    );

    // Reorder buffer side.
    modport slave (
        input  valid_i, in_r, in_i,
        output valid_o, out_r, out_i, idx_o, sop_o, eop_o
    );
endinterface

// File: rtl/fft_pingpong_mem.sv
// Two-bank flop array for the reorder buffer: one synchronous write port,
// one combinational read port. Contents are deliberately not reset.
module fft_pingpong_mem #(
    parameter int N     = fft_pkg::N,
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int DW    = fft_pkg::DW
) (
    input  logic                clk,
    input  logic                we,
    input  logic                wr_bank,
    input  logic [LOG2N-1:0]    wr_addr,
    input  logic [2*DW-1:0]     wr_data,
    input  logic                rd_bank,
    input  logic [LOG2N-1:0]    rd_addr,
    output logic [2*DW-1:0]     rd_data
);

    logic [2*DW-1:0] mem_r [2][N];

    // Store one packed {real, imag} sample per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_bank][rd_addr];

endmodule

// File: rtl/fft_reorder_buf.sv
// Output reorder buffer for the 32-point SDF FFT: collects each frame in
// bit-reversed order into one ping-pong bank and drains it in natural order
// as a gapless burst while the next frame fills the other bank.

// Overlap guard: a frame may only complete while the read side is idle or
// emitting the final sample of the previous frame.
module fft_reorder_buf_chk (
    input logic clk,
    input logic rst,
    input logic frame_done,
    input logic in_drain,
    input logic rd_last
);
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        frame_done |-> (!in_drain || rd_last));
endmodule

module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int N     = fft_pkg::N,
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int DW    = fft_pkg::DW
) (
    input  logic                clk,
    input  logic                rst,
    fft_reorder_buf_if.slave    bus
);

    localparam logic [LOG2N-1:0] ZERO_IDX = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0] ONE_IDX  = LOG2N'(32'd1);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    // Write side
    logic [LOG2N-1:0]       wr_cnt_r;
    logic                   wr_bank_r;
    logic [LOG2N-1:0]       wr_addr_s;
    logic                   wr_en_s;
    logic                   frame_done_s;

    // Read side
    rd_state_e              rd_state_r;
    logic [LOG2N-1:0]       rd_cnt_r;
    logic                   rd_bank_r;
    logic                   emit_s;
    logic                   rd_bank_s;
    logic [LOG2N-1:0]       rd_addr_s;
    logic [2*DW-1:0]        rd_data_s;

    // Registered outputs
    logic                   valid_o_r;
    logic                   sop_o_r;
    logic                   eop_o_r;
    logic signed [DW-1:0]   out_r_r;
    logic signed [DW-1:0]   out_i_r;
    logic [LOG2N-1:0]       idx_o_r;

    // Write address is the bit-reversed arrival count; the last arrival closes the frame.
    always_comb begin
        wr_addr_s    = LOG2N'(bitrev_w(REV_W'(wr_cnt_r), LOG2N));
        frame_done_s = bus.valid_i && (wr_cnt_r == LAST_IDX);
        wr_en_s      = bus.valid_i && !rst;
    end

    // Read location: while draining follow the read counter; otherwise aim at
    // index 0 of the bank being completed so X[0] leaves the cycle after the last input.
    always_comb begin
        if (rd_state_r == R_DRAIN) begin
            emit_s    = 1'b1;
            rd_bank_s = rd_bank_r;
            rd_addr_s = rd_cnt_r;
        end else begin
            emit_s    = frame_done_s;
            rd_bank_s = wr_bank_r;
            rd_addr_s = ZERO_IDX;
        end
    end

    // Write counter and bank select; the counter holds through input gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r  <= ZERO_IDX;
            wr_bank_r <= 1'b0;
        end else if (frame_done_s) begin
            wr_cnt_r  <= ZERO_IDX;
            wr_bank_r <= ~wr_bank_r;
        end else if (bus.valid_i) begin
            wr_cnt_r  <= wr_cnt_r + ONE_IDX;
        end
    end

    // Read FSM with registered output stage; outputs are zero whenever not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r <= R_IDLE;
            rd_cnt_r   <= ZERO_IDX;
            rd_bank_r  <= 1'b0;
            valid_o_r  <= 1'b0;
            sop_o_r    <= 1'b0;
            eop_o_r    <= 1'b0;
            out_r_r    <= {DW{1'b0}};
            out_i_r    <= {DW{1'b0}};
            idx_o_r    <= ZERO_IDX;
        end else begin
            if (emit_s) begin
                valid_o_r <= 1'b1;
                out_r_r   <= rd_data_s[2*DW-1:DW];
                out_i_r   <= rd_data_s[DW-1:0];
                idx_o_r   <= rd_addr_s;
                sop_o_r   <= (rd_addr_s == ZERO_IDX);
                eop_o_r   <= (rd_addr_s == LAST_IDX);
            end else begin
                valid_o_r <= 1'b0;
                out_r_r   <= {DW{1'b0}};
                out_i_r   <= {DW{1'b0}};
                idx_o_r   <= ZERO_IDX;
                sop_o_r   <= 1'b0;
                eop_o_r   <= 1'b0;
            end

            case (rd_state_r)
                R_IDLE: begin
                    if (frame_done_s) begin
                        // X[0] is emitted on this edge, so the drain resumes at index 1.
                        rd_state_r <= R_DRAIN;
                        rd_bank_r  <= wr_bank_r;
                        rd_cnt_r   <= ONE_IDX;
                    end
                end
                R_DRAIN: begin
                    if (rd_cnt_r == LAST_IDX) begin
                        if (frame_done_s) begin
                            // Next frame completes exactly as this one ends: chain without a gap.
                            rd_bank_r <= wr_bank_r;
                            rd_cnt_r  <= ZERO_IDX;
                        end else begin
                            rd_state_r <= R_IDLE;
                            rd_cnt_r   <= ZERO_IDX;
                        end
                    end else begin
                        rd_cnt_r <= rd_cnt_r + ONE_IDX;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    rd_cnt_r   <= ZERO_IDX;
                end
            endcase
        end
    end

    fft_pingpong_mem #(
        .N     (N),
        .LOG2N (LOG2N),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .we      (wr_en_s),
        .wr_bank (wr_bank_r),
        .wr_addr (wr_addr_s),
        .wr_data ({bus.in_r, bus.in_i}),
        .rd_bank (rd_bank_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    fft_reorder_buf_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .frame_done (frame_done_s),
        .in_drain   (rd_state_r == R_DRAIN),
        .rd_last    (rd_cnt_r == LAST_IDX)
    );

    assign bus.valid_o = valid_o_r;
    assign bus.out_r   = out_r_r;
    assign bus.out_i   = out_i_r;
    assign bus.idx_o   = idx_o_r;
    assign bus.sop_o   = sop_o_r;
    assign bus.eop_o   = eop_o_r;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Scoreboard bench for fft_reorder_buf: each complete input frame pushes its
// natural-order samples and their due cycles; the output monitor pops and compares.
module tb_fft_reorder_buf;
    import fft_pkg::*;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic [LOG2N-1:0]     idx;
        int                   cyc;
    } exp_t;

    localparam logic signed [DW-1:0] MAX_S = 19'h3FFFF;
    localparam logic signed [DW-1:0] MIN_S = 19'h40000;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    bit   found;
    exp_t sb_q[$];
    exp_t mon_e;
    logic signed [DW-1:0] fr_r [N];
    logic signed [DW-1:0] fr_i [N];

    fft_reorder_buf_if bus ();

    fft_reorder_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Output monitor: every valid sample must match the scoreboard head, idle cycles must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.valid_o) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out", {59'd0, bus.idx_o}, 64'hFFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("out_r", bus.out_r, mon_e.re);
                    check_eq("out_i", bus.out_i, mon_e.im);
                    check_eq("idx_o", bus.idx_o, mon_e.idx);
                    check_eq("sop_o", bus.sop_o, mon_e.idx == '0);
                    check_eq("eop_o", bus.eop_o, mon_e.idx == LOG2N'(N - 1));
                    check_eq("out_cycle", cyc, mon_e.cyc);
                end
            end else begin
                check_eq("idle_zero", {bus.out_r, bus.out_i, bus.idx_o, bus.sop_o, bus.eop_o}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.valid_i = 1'b0;
            bus.in_r    = '0;
            bus.in_i    = '0;
        end
    endtask

    // Send count samples of fr_r/fr_i in bit-reversed order; a full frame is pushed to the scoreboard.
    task automatic send_frame(input bit gapped, input int count);
        for (int k = 0; k < count; k++) begin
            logic [LOG2N-1:0] a;
            tick();
            a = bitrev(LOG2N'(k));
            bus.valid_i = 1'b1;
            bus.in_r    = fr_r[a];
            bus.in_i    = fr_i[a];
            if (k == N - 1) begin
                for (int n = 0; n < N; n++) begin
                    sb_q.push_back('{re: fr_r[n], im: fr_i[n], idx: LOG2N'(n), cyc: cyc + 1 + n});
                end
            end
            if (gapped && k != count - 1) begin
                tick();
                bus.valid_i = 1'b0;
                bus.in_r    = '0;
                bus.in_i    = '0;
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.in_r    = '0;
        bus.in_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid_o", bus.valid_o, 1'b0);
        check_eq("rst_sop_eop", {bus.sop_o, bus.eop_o}, 2'b00);
        check_eq("rst_data", {bus.out_r, bus.out_i}, 38'd0);
        check_eq("rst_idx_o", bus.idx_o, 5'd0);
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(3);

        // Single contiguous frame: in_r = bitrev(k), in_i = -bitrev(k).
        for (int n = 0; n < N; n++) begin
            fr_r[n] = DW'(n);
            fr_i[n] = DW'(-n);
        end
        send_frame(1'b0, N);
        idle(40);

        // Back-to-back frames, second offset by +100.
        send_frame(1'b0, N);
        for (int n = 0; n < N; n++) begin
            fr_r[n] = DW'(n + 100);
            fr_i[n] = DW'(-(n + 100));
        end
        send_frame(1'b0, N);
        idle(40);

        // Gapped input: valid toggles every cycle.
        for (int n = 0; n < N; n++) begin
            fr_r[n] = DW'(3 * n - 40);
            fr_i[n] = DW'(1000 - 5 * n);
        end
        send_frame(1'b1, N);
        idle(40);

        // Reset mid-input: 10 samples of a discarded frame, reset, then a full frame.
        for (int n = 0; n < N; n++) begin
            fr_r[n] = DW'(999);
            fr_i[n] = DW'(-999);
        end
        send_frame(1'b0, 10);
        tick();
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        tick();
        rst = 1'b0;
        sb_q.delete();
        for (int n = 0; n < N; n++) begin
            fr_r[n] = DW'(n + 50);
            fr_i[n] = DW'(7 * n - 3);
        end
        send_frame(1'b0, N);
        idle(40);

        // Reset mid-drain at output index 7.
        for (int n = 0; n < N; n++) begin
            fr_r[n] = DW'(7 * n);
            fr_i[n] = DW'(3 - 7 * n);
        end
        send_frame(1'b0, N);
        idle(1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.valid_o && bus.idx_o == 5'd7) found = 1'b1;
        end
        check_eq("drain_idx7_seen", found, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_eq("rst_drain_valid", bus.valid_o, 1'b0);
        check_eq("rst_drain_data", {bus.out_r, bus.out_i, bus.idx_o}, 43'd0);
        idle(40);

        // Extreme values, alternating max/min.
        for (int n = 0; n < N; n++) begin
            fr_r[n] = (n % 2 == 1) ? MIN_S : MAX_S;
            fr_i[n] = (n % 2 == 1) ? MAX_S : MIN_S;
        end
        send_frame(1'b0, N);
        idle(5);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
